// File: rtl/irq_request_collector_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_request_collector_if : valid/ready grant channel to the encoder stage
// Revision: 1.0
// ---------------------------------------------------------------------------
interface irq_request_collector_if #(
  parameter int IDX_W = 3
);
  logic             valid_o;
  logic [IDX_W-1:0] idx_o;
  logic             ready_i;

  modport master (output valid_o, output idx_o, input ready_i);
  modport slave  (input valid_o, input idx_o, output ready_i);
endinterface
`default_nettype wire

// File: rtl/irq_request_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_request_collector : sync + edge-detect requests, sticky pending, grant
// Revision: 1.0
// ---------------------------------------------------------------------------
module irq_request_collector #(
  parameter int N           = 8,
  parameter int IDX_W       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_W      = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic [N-1:0]          req_i,
  input  wire logic [N-1:0]          mask_i,
  output logic      [N-1:0]          pending_o,
  output logic      [DROP_W-1:0]     drop_cnt_o,
  irq_request_collector_if.master    irq
);

  localparam logic [DROP_W-1:0] c_drop_max = {DROP_W{1'b1}};

  generate
    if (IDX_W != $clog2(N)) begin : g_chk_idx_w
      $error("IDX_W must equal clog2(N)");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [N-1:0]      r_sync [SYNC_STAGES];
  logic [N-1:0]      r_sync_d;
  logic [N-1:0]      r_pending;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [N-1:0]      w_edge;
  logic [N-1:0]      w_clr;
  logic [N-1:0]      w_elig;
  logic [IDX_W-1:0]  w_sel;
  logic              w_any;
  logic              w_accept;
  logic              w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_sync_d <= '0;
    end else begin
      r_sync[0] <= req_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_sync_d;
  assign w_accept = (r_state == ST_PRESENT) && irq.ready_i;
  assign w_elig   = r_pending & mask_i;
  assign w_any    = |w_elig;
  // A new edge on the bit being served is neither a drop nor lost: set wins.
  assign w_drop   = |(w_edge & r_pending & ~w_clr);

  always_comb begin
    w_clr = '0;
    if (w_accept) begin
      w_clr[r_idx] = 1'b1;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_elig[i]) begin
        w_sel = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (w_drop && (r_drop_cnt != c_drop_max)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // idx is captured only on entry to PRESENT, so it stays stable while presented.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_PRESENT;
          w_idx_nxt   = w_sel;
        end
      end
      ST_PRESENT: begin
        if (irq.ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign irq.valid_o = (r_state == ST_PRESENT);
  assign irq.idx_o   = r_idx;
  assign pending_o   = r_pending;
  assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_irq_request_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_irq_request_collector : directed + random stimulus against a cycle model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_irq_request_collector;

  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int S     = 2;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic [N-1:0]  pend;
  logic [DW-1:0] drop;

  irq_request_collector_if #(.IDX_W(IDX_W)) irq ();

  irq_request_collector #(
    .N(N), .IDX_W(IDX_W), .SYNC_STAGES(S), .DROP_W(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .mask_i     (mask),
    .pending_o  (pend),
    .drop_cnt_o (drop),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_hist[j] is the raw request sampled j edges ago.
  logic [N-1:0] m_hist [0:S];
  logic [N-1:0] m_pend;
  int           m_cnt;
  bit           m_busy;
  int           m_idx;
  int           grants[$];

  task automatic model_reset();
    for (int j = 0; j <= S; j++) m_hist[j] = '0;
    m_pend = '0;
    m_cnt  = 0;
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] ev, clr, elig;
    ev  = m_hist[S-1] & ~m_hist[S];
    clr = '0;
    if (m_busy && irq.ready_i) clr[m_idx] = 1'b1;
    if ((ev & m_pend & ~clr) != 0 && m_cnt < 255) m_cnt++;
    if (m_busy) begin
      if (irq.ready_i) m_busy = 1'b0;
    end else begin
      elig = m_pend & mask;
      for (int i = N - 1; i >= 0; i--) begin
        if (elig[i]) begin
          m_idx  = i;
          m_busy = 1'b1;
          break;
        end
      end
    end
    m_pend = (m_pend & ~clr) | ev;
    for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = req;
  endtask

  task automatic compare();
    check("valid", irq.valid_o, m_busy);
    check("pending", pend, m_pend);
    check("drop_cnt", drop, m_cnt);
    if (m_busy) check("idx", irq.idx_o, m_idx);
  endtask

  task automatic tick();
    if (irq.valid_o && irq.ready_i) grants.push_back(int'(irq.idx_o));
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [DW-1:0] d0;
    rst_n       = 1'b0;
    req         = '0;
    mask        = 8'hFF;
    irq.ready_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", irq.valid_o, 0);
    check("rst_idx", irq.idx_o, 0);
    check("rst_pending", pend, 0);
    check("rst_drop", drop, 0);
    rst_n = 1'b1;

    // single event, latency SYNC_STAGES to pending and +1 to valid
    irq.ready_i = 1'b1;
    req = 8'h04;
    ticks(3);
    req = 8'h00;
    check("single_pend", pend, 8'h04);
    check("single_nvalid", irq.valid_o, 0);
    tick();
    check("single_valid", irq.valid_o, 1);
    check("single_idx", irq.idx_o, 2);
    tick();
    check("single_clear", pend, 0);
    ticks(2);

    // priority order 7,5,1 with a long stall on 7
    irq.ready_i = 1'b0;
    req = 8'hA2;
    ticks(3);
    req = 8'h00;
    tick();
    check("prio_first", irq.idx_o, 7);
    ticks(9);
    check("prio_held", irq.idx_o, 7);
    check("prio_held_v", irq.valid_o, 1);
    grants.delete();
    irq.ready_i = 1'b1;
    ticks(8);
    check("prio_ngrants", grants.size(), 3);
    if (grants.size() == 3) begin
      check("prio_g0", grants[0], 7);
      check("prio_g1", grants[1], 5);
      check("prio_g2", grants[2], 1);
    end

    // masking: bit 7 pending but disabled, bit 0 served first
    irq.ready_i = 1'b0;
    mask = 8'h7F;
    req  = 8'h81;
    ticks(3);
    req = 8'h00;
    ticks(2);
    check("mask_pend", pend, 8'h81);
    check("mask_idx0", irq.idx_o, 0);
    irq.ready_i = 1'b1;
    tick();
    irq.ready_i = 1'b0;
    mask = 8'hFF;
    ticks(2);
    check("mask_idx7", irq.idx_o, 7);
    check("mask_pend7", pend, 8'h80);
    irq.ready_i = 1'b1;
    ticks(3);

    // drop counter saturation
    irq.ready_i = 1'b0;
    for (int e = 0; e < 300; e++) begin
      req = 8'h08;
      tick();
      req = 8'h00;
      tick();
    end
    ticks(4);
    check("drop_sat", drop, 255);
    check("drop_pend3", pend[3], 1);
    ticks(3);
    check("drop_hold", drop, 255);
    irq.ready_i = 1'b1;
    ticks(4);

    // collision: new edge on bit 6 in the accept cycle of idx 6
    irq.ready_i = 1'b0;
    req = 8'h40;
    ticks(3);
    req = 8'h00;
    ticks(3);
    check("coll_present", irq.idx_o, 6);
    d0  = drop;
    req = 8'h40;
    ticks(2);
    irq.ready_i = 1'b1;
    tick();
    check("coll_pend6", pend[6], 1);
    check("coll_drop", drop, d0);
    req = 8'h00;
    tick();
    check("coll_regrant_v", irq.valid_o, 1);
    check("coll_regrant", irq.idx_o, 6);
    ticks(3);

    // asynchronous reset while presenting
    irq.ready_i = 1'b0;
    req = 8'h10;
    ticks(3);
    req = 8'h00;
    ticks(2);
    check("arst_pre", irq.valid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", irq.valid_o, 0);
    check("arst_idx", irq.idx_o, 0);
    check("arst_pend", pend, 0);
    check("arst_drop", drop, 0);
    model_reset();
    #1 rst_n = 1'b1;
    irq.ready_i = 1'b1;
    ticks(10);
    check("arst_nogrant", irq.valid_o, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req  = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      irq.ready_i = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_request_collector.md
Name: irq_request_collector

Overview:
- Upstream stage of the 8-to-3 priority encoder path.
- Synchronises eight request lines and edge-detects them into sticky pending bits.
- Masks the pending bits, picks the highest-priority pending index (bit 7 highest, same ordering as the encoder) and presents it to the consumer.
- Uses a valid/ready handshake; the served pending bit clears on acceptance.

Parameters:
N, 8, number of request lines
IDX_W, 3, index width; must equal clog2(N)
SYNC_STAGES, 2, synchroniser flops per request line; minimum 2
DROP_W, 8, width of the saturating dropped-request counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_i  input  N  raw request lines; asynchronous to clk; a rising edge is an event
mask_i  input  N  1 = line enabled; synchronous to clk
pending_o  output  N  sticky pending register (unmasked view)
valid_o  output  1  idx_o holds a served request
idx_o  output  IDX_W  index of the request being presented
ready_i  input  1  consumer accepts idx_o when valid_o=1 and ready_i=1
drop_cnt_o  output  DROP_W  count of events lost because the bit was already pending; saturates at all-ones

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all synchroniser flops, edge flops, pending_o, valid_o, idx_o and drop_cnt_o are 0; FSM is in IDLE.
- Reset asserted mid-handshake drops everything, with no partial clear.
- Sync: each req_i bit passes through SYNC_STAGES flops.
  - sync_q is the last stage; sync_d is sync_q delayed by one clock.
  - edge[i] = sync_q[i] & ~sync_d[i].
- Pending set: on the clock where edge[i]=1, pending[i] is set to 1.
  - Masking does not block setting; a masked line still latches as pending.
- Drop: if edge[i]=1 while pending[i] is already 1 and the bit is not being cleared that cycle, drop_cnt increments.
  - Several simultaneous drops in one cycle still add exactly 1.
  - The counter holds at 2^DROP_W-1.
- Eligible set: elig = pending & mask_i.
  - Selection is the highest set index of elig.
- FSM, two states:
  - IDLE: valid_o=0. If elig is non-zero at a clock edge, load idx_o with the selected index, set valid_o=1 and go to PRESENT.
  - PRESENT: valid_o=1 and idx_o is held stable, independent of later changes to pending or mask_i. No retraction.
  - On a clock with ready_i=1 in PRESENT: clear pending[idx_o], drop valid_o to 0 and go to IDLE.
  - There is always at least one IDLE cycle between grants, so sustained throughput is one grant per 2 clocks.
- Latency: req_i high before edge k, with the line idle and enabled and the FSM in IDLE:
  - pending[i]=1 after edge k+SYNC_STAGES;
  - valid_o=1 after edge k+SYNC_STAGES+1.
- Simultaneous set and clear on the same bit (new edge on idx_o in the accept cycle): set wins, pending stays 1, no drop counted.
- ready_i while in IDLE is ignored.
- Lower-priority pending bits are served only after all higher eligible bits have been accepted.
- Starvation is accepted by design.
- A pending bit whose mask goes to 0 stays pending and is served once it is re-enabled.
- Level-held requests generate one event only. Re-triggering needs req_i to return to 0 for at least one synchronised sample.

Test Plan:
- Single event: pulse req_i=8'h04 for 3 clocks, mask_i=8'hFF, ready_i=1 → valid_o rises after edge k+3 with idx_o=2; accepted the next cycle; pending_o returns to 8'h00.
- Priority: events on bits 1, 5 and 7 together, ready_i=0 for 10 clocks, then 1 → idx_o=7 held for all 10 clocks, then grants 5, then 1, each separated by one valid_o=0 cycle.
- Mask: pending=8'h81, mask_i=8'h7F → idx_o=0 served first; bit 7 stays pending. Then mask_i=8'hFF → idx_o=7.
- Drop and saturation: 300 events on bit 3 while ready_i=0 → drop_cnt_o=255 and holds; pending_o[3]=1.
- Set and clear collision: new edge on bit 6 arrives in the same clock that idx_o=6 is accepted → pending_o[6] remains 1, drop_cnt_o unchanged, a second grant of 6 follows.
- Reset mid-PRESENT: rst_n low asynchronously while valid_o=1 → valid_o, idx_o, pending_o and drop_cnt_o are 0 immediately. After release, no grant until a fresh edge arrives.
